// File: rtl/npu_conv_pkg.sv
// Shared types and constants for the sequential 3x3 convolution MAC engine
// and the parallel conv engines built from the same mac_unit.
package npu_conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int KERNEL_TAPS = 9;
  localparam int TAP_ADDR_W  = 4;

  // 9 taps of 255 * -128 reach -293760, which needs 20 signed bits.
  localparam int MIN_ACC_W   = 20;

  // Signed width of one unsigned-pixel x signed-weight product.
  function automatic int prod_width(input int bit_depth);
    return 2 * bit_depth + 1;
  endfunction

endpackage

// File: rtl/conv_mac_seq_if.sv
// Window-in / result-out handshake bundle plus the weight store read port.
interface conv_mac_seq_if #(
  parameter int BIT_DEPTH = 8,
  parameter int ACC_WIDTH = 20
);
  import npu_conv_pkg::*;

  logic [KERNEL_TAPS*BIT_DEPTH-1:0] win_in;
  logic                             win_valid;
  logic                             win_ready;
  logic [TAP_ADDR_W-1:0]            kernel_addr;
  logic [BIT_DEPTH:0]               kernel_data;
  logic signed [ACC_WIDTH-1:0]      res_out;
  logic                             res_valid;
  logic                             res_ready;
  logic                             busy;

  modport master (
    output win_in, win_valid, kernel_data, res_ready,
    input  win_ready, kernel_addr, res_out, res_valid, busy
  );

  modport slave (
    input  win_in, win_valid, kernel_data, res_ready,
    output win_ready, kernel_addr, res_out, res_valid, busy
  );

endinterface

// File: rtl/conv_mac_seq_mac_unit.sv
// Unsigned pixel x signed weight multiply-accumulate with synchronous clear.
// Latency: sum is combinational, acc updates on the enabled edge.
// Backpressure: none; caller gates with en/clr.
module mac_unit
  import npu_conv_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic [BIT_DEPTH-1:0]        pixel,
  input  logic signed [BIT_DEPTH-1:0] weight,
  output logic signed [ACC_WIDTH-1:0] acc,
  output logic signed [ACC_WIDTH-1:0] sum
);

  localparam int PROD_W = prod_width(BIT_DEPTH);

  logic signed [PROD_W-1:0] pix_ext;
  logic signed [PROD_W-1:0] wt_ext;
  logic signed [PROD_W-1:0] prod;

  // Pixel is zero-extended, weight sign-extended; the product fits PROD_W exactly.
  assign pix_ext = $signed(PROD_W'({1'b0, pixel}));
  assign wt_ext  = PROD_W'(weight);
  assign prod    = pix_ext * wt_ext;
  assign sum     = acc + ACC_WIDTH'(prod);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/conv_mac_seq.sv
// Sequential 3x3 conv: one window per handshake, one weight read per cycle.
// Latency: result valid 9 cycles after window accept; initiation interval >= 11.
// Backpressure: result held in DONE while res_ready low; win_ready low outside IDLE.
module conv_mac_seq
  import npu_conv_pkg::*;
#(
  parameter int BIT_DEPTH   = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int ACC_WIDTH   = 20,
  parameter int RELU_EN     = 0
) (
  input logic           clk,
  input logic           rst,
  conv_mac_seq_if.slave bus
);

  localparam int TAPS = KERNEL_SIZE * KERNEL_SIZE;
  localparam logic [TAP_ADDR_W-1:0] LAST_TAP = TAP_ADDR_W'(TAPS - 1);

  state_t                       state_q;
  state_t                       state_d;
  logic [TAP_ADDR_W-1:0]        count_q;
  logic [TAPS*BIT_DEPTH-1:0]    win_q;
  logic signed [ACC_WIDTH-1:0]  res_q;
  logic                         res_vld_q;

  logic                         win_rdy;
  logic                         busy_d;
  logic [TAP_ADDR_W-1:0]        kaddr_d;
  logic                         accept;
  logic                         in_mac;
  logic                         last_tap;
  logic [BIT_DEPTH-1:0]         pixel;
  logic signed [BIT_DEPTH-1:0]  weight;
  logic signed [ACC_WIDTH-1:0]  mac_acc;
  logic signed [ACC_WIDTH-1:0]  mac_sum;
  logic signed [ACC_WIDTH-1:0]  res_d;
  logic                         unused_kdata_msb;

  assign accept   = (state_q == ST_IDLE) && bus.win_valid;
  assign in_mac   = (state_q == ST_MAC);
  assign last_tap = in_mac && (count_q == LAST_TAP);

  // The store's extra top bit carries no weight information here.
  assign weight           = $signed(bus.kernel_data[BIT_DEPTH-1:0]);
  assign unused_kdata_msb = bus.kernel_data[BIT_DEPTH];

  always_comb begin
    pixel = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (count_q == TAP_ADDR_W'(i)) begin
        pixel = win_q[i*BIT_DEPTH +: BIT_DEPTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_rdy = 1'b0;
    busy_d  = 1'b0;
    kaddr_d = '0;
    case (state_q)
      ST_IDLE: begin
        win_rdy = 1'b1;
        if (bus.win_valid) begin
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        busy_d  = 1'b1;
        kaddr_d = count_q;
        if (count_q == LAST_TAP) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mac_unit #(
    .BIT_DEPTH (BIT_DEPTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (in_mac),
    .pixel  (pixel),
    .weight (weight),
    .acc    (mac_acc),
    .sum    (mac_sum)
  );

  // Final tap's sum goes straight to the output register; acc itself is not reused.
  assign res_d = ((RELU_EN != 0) && mac_sum[ACC_WIDTH-1]) ? '0 : mac_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      win_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        win_q   <= bus.win_in;
        count_q <= '0;
      end else if (in_mac) begin
        count_q <= count_q + 1'b1;
      end
      if (last_tap) begin
        res_q     <= res_d;
        res_vld_q <= 1'b1;
      end else if ((state_q == ST_DONE) && bus.res_ready) begin
        res_vld_q <= 1'b0;
      end
    end
  end

  assign bus.win_ready   = win_rdy;
  assign bus.busy        = busy_d;
  assign bus.kernel_addr = kaddr_d;
  assign bus.res_out     = res_q;
  assign bus.res_valid   = res_vld_q;

endmodule

// File: doc/conv_mac_seq.md
Name: conv_mac_seq

Overview:
Downstream consumer of the 3x3 kernel weight store. Accepts one 3x3 pixel window per handshake and steps kernel_addr through taps 0..8, reading one weight per cycle. Accumulates pixel*weight and presents one convolution result per window on a valid/ready output. Asserts a busy flag so the weight loader does not rewrite weights mid-window.

Parameters:
BIT_DEPTH, 8, pixel width; kernel weight width as stored
KERNEL_SIZE, 3, kernel edge; taps = KERNEL_SIZE*KERNEL_SIZE = 9
ACC_WIDTH, 20, signed accumulator/result width; must be >= 20 for 8-bit defaults
RELU_EN, 0, 1 = clamp negative results to 0 at output register

Ports:
clk  in  1  rising-edge clock (single clock domain)
rst  in  1  synchronous, active-high reset
win_in  in  9*BIT_DEPTH  window pixels, unsigned; tap i at [i*BIT_DEPTH +: BIT_DEPTH], i = row*3+col
win_valid  in  1  window present
win_ready  out  1  block accepts window
kernel_addr  out  4  tap address to weight store
kernel_data  in  BIT_DEPTH+1  weight from store, combinational read of kernel_addr; low BIT_DEPTH bits used, two's complement signed
res_out  out  ACC_WIDTH  signed convolution result
res_valid  out  1  result present
res_ready  in  1  downstream accepts result
busy  out  1  high while weights are being read (MAC state)

Behaviour:
- Reset (rst=1 at posedge): state IDLE, tap count 0, acc 0, res_out 0, res_valid 0, busy 0, kernel_addr 0; win_ready 1 after reset. Reset mid-window or mid-hold aborts; no partial result emitted.
- FSM IDLE -> MAC -> DONE -> IDLE.
- IDLE: win_ready=1, kernel_addr=0, busy=0. On win_valid&&win_ready: latch win_in into window register, acc<=0, count<=0, -> MAC.
- MAC (exactly 9 cycles, count 0..8): kernel_addr=count (combinational from count), busy=1, win_ready=0. Each cycle: product = zero-extended pixel[count] (BIT_DEPTH+1 signed) * signed kernel_data[BIT_DEPTH-1:0]; acc <= acc + sign-extended product. At count==8: res_out <= acc+product (clamped to 0 if RELU_EN and negative), res_valid<=1, -> DONE.
- DONE: res_valid=1, res_out stable, win_ready=0, busy=0. On res_ready: res_valid<=0 -> IDLE. Holds indefinitely under backpressure.
- Latency: window accepted at edge T; res_valid high from edge T+9. Minimum 11-cycle initiation interval (accept, 9 MAC, 1 DONE-with-ready); next window accepted in IDLE.
- Width: max |product| 128*255 = 32640; 9 taps -> |sum| <= 293760 < 2^19; ACC_WIDTH=20 never overflows, no saturation logic.
- win_valid while not in IDLE is ignored (not latched). win_in changes after acceptance do not affect the result.
- kernel_data bit BIT_DEPTH ignored.
- Weights written by loader during MAC are a system error; busy exists to prevent it, no internal protection.

Decomposition:
- Package npu_conv_pkg: state enum (IDLE, MAC, DONE), KERNEL_TAPS=9 constant, TAP_ADDR_W=4, min-accumulator-width constant for default depth.
- One sub-module natural: mac_unit (unsigned pixel x signed weight multiply, sign-extend, accumulate with clear), reused by later parallel conv engines.

Test Plan:
- Weights all +1, pixels all 10 -> res_out=90, res_valid at T+9, kernel_addr observed 0,1,...,8 on MAC cycles.
- Weights all -128 (0x80), pixels all 255 -> res_out=-293760 (RELU_EN=0); with RELU_EN=1 -> 0.
- Weights [1,2,...,9], pixels [9,...,1] -> res_out=165; bit 8 of kernel_data toggled randomly has no effect.
- res_ready held 0 for 20 cycles after result -> res_valid and res_out stable, win_ready=0, second win_valid not accepted; release -> IDLE, next window accepted following cycle.
- rst asserted at MAC count 4 -> next cycle IDLE, res_valid=0, busy=0, win_ready=1; following window computes correctly from acc 0.
- Back-to-back windows with win_valid held high -> accepts exactly one per 11 cycles with res_ready=1, busy high exactly 9 cycles each.
